// File: rtl/conv_frame_source.sv
// conv_frame_source: stimulus transmitter for the convolution filter input side.
// On start it shifts the 5x5 coefficient mask out over io_config_load/io_coeff_in. It then
// streams num_frames raster frames back-to-back on io_frame_sync_in/io_data_in.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   start, num_frames   run request (taken only when idle) and frame count for the run
//   coeff_wr_*          host writes into the coefficient RAM (idle only)
//   pix_rd_en/pix_addr  pixel memory read port; pix_rd_data returns one cycle later
//   io_*                filter-facing coefficient and pixel stream
//   busy, done          run in progress / one-cycle end-of-run pulse
//
// Build option: define CONV_SRC_LFSR_EN to source pixels from an internal 8-bit LFSR
// (x^8+x^6+x^5+x^4+1, seeded 8'h01 on start) instead of the pixel memory.
module conv_frame_source #(
  parameter int unsigned IMAGE_WIDTH  = 128,
  parameter int unsigned IMAGE_HEIGHT = 128,
  parameter int unsigned COEFF_WIDTH  = 16,
  parameter int unsigned NUM_COEFFS   = 25,
  parameter int unsigned ADDR_WIDTH   = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            num_frames,
  input  logic                   coeff_wr_en,
  input  logic [4:0]             coeff_wr_addr,
  input  logic [COEFF_WIDTH-1:0] coeff_wr_data,
  output logic                   pix_rd_en,
  output logic [ADDR_WIDTH-1:0]  pix_addr,
  input  logic [7:0]             pix_rd_data,
  output logic                   io_config_load,
  output logic [COEFF_WIDTH-1:0] io_coeff_in,
  output logic                   io_frame_sync_in,
  output logic [7:0]             io_data_in,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned NumPix = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NumPix - 1);
  localparam logic [4:0] LastCoeff = 5'(NUM_COEFFS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StStream, StFinish} state_e;

  state_e                 state_q, state_d;
  logic [COEFF_WIDTH-1:0] coeff_q [NUM_COEFFS];
  logic [COEFF_WIDTH-1:0] coeff_d [NUM_COEFFS];
  logic [15:0]            num_frames_q, num_frames_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic [4:0]             coeff_idx_q, coeff_idx_d;
  logic [ADDR_WIDTH-1:0]  pix_cnt_q, pix_cnt_d;
  logic                   rd_done_q, rd_done_d;   // all reads issued, pipeline draining
  logic                   drain_q, drain_d;
  // Pipeline: issue (iss) -> memory data valid (val1) -> output register
  logic                   iss_q, iss_d, iss_sync_q, iss_sync_d;
  logic                   val1_q, val1_d, sync1_q, sync1_d;
  logic [ADDR_WIDTH-1:0]  pix_addr_q, pix_addr_d;
  logic                   cfg_q, cfg_d;
  logic [COEFF_WIDTH-1:0] coeff_out_q, coeff_out_d;
  logic                   fsync_q, fsync_d;
  logic [7:0]             data_q, data_d;
  logic                   busy_q, busy_d, done_q, done_d;
  logic                   start_go;
  logic [7:0]             pix_src;

  // busy_q stays high through the done cycle, so gating on it keeps start and writes out
  // until the run has fully ended.
  assign start_go = (state_q == StIdle) && !busy_q && start;

`ifdef CONV_SRC_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       unused_pix;

  assign unused_pix = ^{pix_rd_data, pix_addr_q, iss_q};
  assign pix_src    = lfsr_q;

  // Advances once per pixel entering the output register, keeping memory-path alignment.
  always_comb begin
    lfsr_d = lfsr_q;
    if (start_go) begin
      lfsr_d = 8'h01;
    end else if (val1_q) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) lfsr_q <= 8'h00;
    else        lfsr_q <= lfsr_d;
  end

  assign pix_rd_en = 1'b0;
  assign pix_addr  = '0;
`else
  assign pix_src   = pix_rd_data;
  assign pix_rd_en = iss_q;
  assign pix_addr  = pix_addr_q;
`endif

  always_comb begin
    state_d      = state_q;
    coeff_d      = coeff_q;
    num_frames_d = num_frames_q;
    frame_cnt_d  = frame_cnt_q;
    coeff_idx_d  = coeff_idx_q;
    pix_cnt_d    = pix_cnt_q;
    rd_done_d    = rd_done_q;
    drain_d      = drain_q;
    iss_d        = 1'b0;
    iss_sync_d   = 1'b0;
    pix_addr_d   = '0;
    cfg_d        = 1'b0;
    coeff_out_d  = '0;
    done_d       = 1'b0;
    val1_d       = iss_q;
    sync1_d      = iss_sync_q;
    data_d       = val1_q ? pix_src : 8'h00;
    fsync_d      = val1_q & sync1_q;

    unique case (state_q)
      StIdle: begin
        if (!busy_q && coeff_wr_en && (coeff_wr_addr < 5'(NUM_COEFFS))) begin
          coeff_d[coeff_wr_addr] = coeff_wr_data;
        end
        if (start_go) begin
          num_frames_d = num_frames;
          frame_cnt_d  = '0;
          coeff_idx_d  = '0;
          pix_cnt_d    = '0;
          rd_done_d    = 1'b0;
          drain_d      = 1'b0;
          state_d      = StLoad;
        end
      end
      StLoad: begin
        cfg_d       = 1'b1;
        coeff_out_d = coeff_q[coeff_idx_q];
        if (coeff_idx_q == LastCoeff) begin
          state_d = (num_frames_q == 16'd0) ? StFinish : StStream;
        end else begin
          coeff_idx_d = coeff_idx_q + 5'd1;
        end
      end
      StStream: begin
        if (!rd_done_q) begin
          iss_d      = 1'b1;
          pix_addr_d = pix_cnt_q;
          iss_sync_d = (pix_cnt_q == '0);
          if (pix_cnt_q == LastAddr) begin
            pix_cnt_d   = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (frame_cnt_q + 16'd1 == num_frames_q) rd_done_d = 1'b1;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end else if (drain_q) begin
          state_d = StFinish;
        end else begin
          drain_d = 1'b1;
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle) || done_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      for (int i = 0; i < int'(NUM_COEFFS); i++) coeff_q[i] <= '0;
      num_frames_q <= '0;
      frame_cnt_q  <= '0;
      coeff_idx_q  <= '0;
      pix_cnt_q    <= '0;
      rd_done_q    <= 1'b0;
      drain_q      <= 1'b0;
      iss_q        <= 1'b0;
      iss_sync_q   <= 1'b0;
      val1_q       <= 1'b0;
      sync1_q      <= 1'b0;
      pix_addr_q   <= '0;
      cfg_q        <= 1'b0;
      coeff_out_q  <= '0;
      fsync_q      <= 1'b0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      coeff_q      <= coeff_d;
      num_frames_q <= num_frames_d;
      frame_cnt_q  <= frame_cnt_d;
      coeff_idx_q  <= coeff_idx_d;
      pix_cnt_q    <= pix_cnt_d;
      rd_done_q    <= rd_done_d;
      drain_q      <= drain_d;
      iss_q        <= iss_d;
      iss_sync_q   <= iss_sync_d;
      val1_q       <= val1_d;
      sync1_q      <= sync1_d;
      pix_addr_q   <= pix_addr_d;
      cfg_q        <= cfg_d;
      coeff_out_q  <= coeff_out_d;
      fsync_q      <= fsync_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign io_config_load   = cfg_q;
  assign io_coeff_in      = coeff_out_q;
  assign io_frame_sync_in = fsync_q;
  assign io_data_in       = data_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_conv_frame_source.sv
// Directed bench for conv_frame_source (default build, 128x128 frames).
module tb_conv_frame_source;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] num_frames;
  logic        coeff_wr_en;
  logic [4:0]  coeff_wr_addr;
  logic [15:0] coeff_wr_data;
  logic        pix_rd_en;
  logic [13:0] pix_addr;
  logic [7:0]  pix_rd_data = 8'h00;
  logic        io_config_load;
  logic [15:0] io_coeff_in;
  logic        io_frame_sync_in;
  logic [7:0]  io_data_in;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conv_frame_source dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .num_frames       (num_frames),
    .coeff_wr_en      (coeff_wr_en),
    .coeff_wr_addr    (coeff_wr_addr),
    .coeff_wr_data    (coeff_wr_data),
    .pix_rd_en        (pix_rd_en),
    .pix_addr         (pix_addr),
    .pix_rd_data      (pix_rd_data),
    .io_config_load   (io_config_load),
    .io_coeff_in      (io_coeff_in),
    .io_frame_sync_in (io_frame_sync_in),
    .io_data_in       (io_data_in),
    .busy             (busy),
    .done             (done)
  );

  // Pixel memory: pix[k] = k[7:0], one-cycle read latency.
  always @(posedge clk) if (pix_rd_en) pix_rd_data <= pix_addr[7:0];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {21'd0, pix_rd_en, pix_addr, io_config_load, io_coeff_in, io_frame_sync_in,
            io_data_in, busy, done};
  endfunction

  logic [15:0] exp_coeff [25];

  // Runs a num_frames=0 load; optional coefficient write in the same cycle as start.
  task automatic run_load(input string tag, input logic wr, input logic [4:0] wa,
                          input logic [15:0] wd);
    logic rd_seen = 1'b0;
    int   cfg_err = 0;
    start = 1'b1; num_frames = 16'd0;
    coeff_wr_en = wr; coeff_wr_addr = wa; coeff_wr_data = wd;
    @(negedge clk);
    start = 1'b0; coeff_wr_en = 1'b0;
    chk({tag, "_busy0"}, 64'(busy), 64'd1);
    for (int n = 1; n <= 27; n++) begin
      @(negedge clk);
      rd_seen |= pix_rd_en;
      if (n <= 25) begin
        if (io_config_load !== 1'b1 || io_coeff_in !== exp_coeff[n-1]) cfg_err++;
      end else if (io_config_load !== 1'b0 || io_coeff_in !== 16'h0) begin
        cfg_err++;
      end
      if (n == 1)  chk({tag, "_coeff0"}, 64'(io_coeff_in), 64'(exp_coeff[0]));
      if (n == 25) chk({tag, "_coeff24"}, 64'(io_coeff_in), 64'(exp_coeff[24]));
      if (n == 26) chk({tag, "_done"}, 64'({done, busy}), 64'b11);
      if (n == 27) chk({tag, "_idle"}, 64'({done, busy}), 64'b00);
    end
    chk({tag, "_coeff_seq_errs"}, 64'(cfg_err), 64'd0);
    chk({tag, "_no_rd"}, 64'(rd_seen), 64'd0);
  endtask

  typedef struct {
    int          n;
    logic        rd;
    logic [13:0] addr;
    logic [7:0]  data;
    logic        sync;
    logic        cfg;
    logic        done;
    logic        busy;
  } svec_t;

  svec_t sv [12];

  initial begin
    int data_err, sync_cnt, done_cnt;

    sv[0]  = '{n: 0,     rd: 0, addr: 0,     data: 8'h00, sync: 0, cfg: 0, done: 0, busy: 1};
    sv[1]  = '{n: 25,    rd: 0, addr: 0,     data: 8'h00, sync: 0, cfg: 1, done: 0, busy: 1};
    sv[2]  = '{n: 26,    rd: 1, addr: 0,     data: 8'h00, sync: 0, cfg: 0, done: 0, busy: 1};
    sv[3]  = '{n: 27,    rd: 1, addr: 1,     data: 8'h00, sync: 0, cfg: 0, done: 0, busy: 1};
    sv[4]  = '{n: 28,    rd: 1, addr: 2,     data: 8'h00, sync: 1, cfg: 0, done: 0, busy: 1};
    sv[5]  = '{n: 29,    rd: 1, addr: 3,     data: 8'h01, sync: 0, cfg: 0, done: 0, busy: 1};
    sv[6]  = '{n: 16411, rd: 1, addr: 1,     data: 8'hFF, sync: 0, cfg: 0, done: 0, busy: 1};
    sv[7]  = '{n: 16412, rd: 1, addr: 2,     data: 8'h00, sync: 1, cfg: 0, done: 0, busy: 1};
    sv[8]  = '{n: 32793, rd: 1, addr: 16383, data: 8'hFD, sync: 0, cfg: 0, done: 0, busy: 1};
    sv[9]  = '{n: 32795, rd: 0, addr: 0,     data: 8'hFF, sync: 0, cfg: 0, done: 0, busy: 1};
    sv[10] = '{n: 32796, rd: 0, addr: 0,     data: 8'h00, sync: 0, cfg: 0, done: 1, busy: 1};
    sv[11] = '{n: 32797, rd: 0, addr: 0,     data: 8'h00, sync: 0, cfg: 0, done: 0, busy: 0};

    reset = 1'b0; start = 1'b0; num_frames = 16'd0;
    coeff_wr_en = 1'b0; coeff_wr_addr = 5'd0; coeff_wr_data = 16'h0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Coefficients 0..23 written alone; 24 written together with start below.
    for (int i = 0; i < 25; i++) exp_coeff[i] = 16'h0100 + 16'(i);
    for (int i = 0; i < 24; i++) begin
      coeff_wr_en = 1'b1; coeff_wr_addr = 5'(i); coeff_wr_data = 16'h0100 + 16'(i);
      @(negedge clk);
    end
    coeff_wr_en = 1'b1; coeff_wr_addr = 5'd25; coeff_wr_data = 16'hDEAD;
    @(negedge clk);
    coeff_wr_en = 1'b0;
    run_load("load", 1'b1, 5'd24, 16'h0118);

    // Two-frame stream with a start and coefficient write injected mid-run.
    start = 1'b1; num_frames = 16'd2;
    @(negedge clk);
    start = 1'b0;
    data_err = 0; sync_cnt = 0; done_cnt = 0;
    for (int n = 0; n <= 32800; n++) begin
      int j;
      if (n > 0) @(negedge clk);
      if (n == 1000) begin
        start = 1'b1; num_frames = 16'd7;
        coeff_wr_en = 1'b1; coeff_wr_addr = 5'd3; coeff_wr_data = 16'hFFFF;
      end else if (n == 1001) begin
        start = 1'b0; coeff_wr_en = 1'b0;
      end
      for (int v = 0; v < 12; v++) begin
        if (sv[v].n == n) begin
          chk($sformatf("stream_n%0d", n),
              64'({pix_rd_en, pix_addr, io_data_in, io_frame_sync_in, io_config_load, done, busy}),
              64'({sv[v].rd, sv[v].addr, sv[v].data, sv[v].sync, sv[v].cfg, sv[v].done,
                   sv[v].busy}));
        end
      end
      j = n - 28;
      if (j >= 0 && j < 32768) begin
        if (io_data_in !== 8'(j) || io_frame_sync_in !== (j == 0 || j == 16384)) data_err++;
      end else if (io_data_in !== 8'h00 || io_frame_sync_in !== 1'b0) begin
        data_err++;
      end
      if (io_frame_sync_in === 1'b1) sync_cnt++;
      if (done === 1'b1) done_cnt++;
    end
    chk("stream_pixel_errs", 64'(data_err), 64'd0);
    chk("stream_sync_count", 64'(sync_cnt), 64'd2);
    chk("stream_done_count", 64'(done_cnt), 64'd1);

    // coeff[3] must be untouched by the write attempted while busy.
    run_load("reload", 1'b0, 5'd0, 16'h0);

    // Reset mid-stream: outputs clear on the first reset edge, RAM is cleared.
    start = 1'b1; num_frames = 16'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_reset_outputs", all_outs(), 64'd0);
    repeat (2) @(negedge clk);
    chk("mid_reset_hold", all_outs(), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 25; i++) exp_coeff[i] = 16'h0;
    run_load("cleared", 1'b0, 5'd0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
